// File: rtl/mem_responder_if.sv
// Core-side bus of the memory responder: request, address, write data,
// read data and the one-cycle ready completion pulse.
interface mem_responder_if;
   logic        req;
   logic [15:0] addr;
   logic        we;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        ready;

   modport master (output req, output addr, output we, output wdata,
                   input rdata, input ready);
   modport slave  (input req, input addr, input we, input wdata,
                   output rdata, output ready);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the 6502 core bus: RAM, write-protected ROM
// holding the reset vectors, a test mailbox register, programmable wait
// states and a ROM side-load port usable at any time, even in reset.
module mem_responder #(
   parameter int          RAM_BYTES   = 4096,
   parameter logic [15:0] ROM_BASE    = 16'hF000,
   parameter logic [15:0] MBOX_ADDR   = 16'h8000,
   parameter int          WAIT_STATES = 0
) (
   input  logic            ph1,
   input  logic            reset,
   mem_responder_if.slave  bus,
   input  logic            load_en,
   input  logic [11:0]     load_addr,
   input  logic [7:0]      load_data,
   output logic            test_done,
   output logic [7:0]      test_code,
   output logic            err_rom_write
);

   localparam int          ROM_BYTES = 32'h10000 - 32'(ROM_BASE);
   localparam int          RAM_AW    = $clog2(RAM_BYTES);
   localparam int          ROM_AW    = $clog2(ROM_BYTES);
   localparam logic [3:0]  WS_M1     = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [15:0] addr_reg;
   logic        we_reg;
   logic [7:0]  wdata_reg;
   logic [7:0]  rdata_reg;
   logic        ready_reg;
   logic        done_reg;
   logic [7:0]  code_reg;
   logic        err_reg;

   logic        cap;
   logic        access;
   logic [15:0] acc_addr;
   logic        acc_we;
   logic [7:0]  acc_wdata;
   logic        is_ram, is_rom, is_mbox;

   logic [7:0]  ram_mem [RAM_BYTES];
   logic [7:0]  rom_mem [ROM_BYTES];

   // Next-state logic; with zero wait states the access happens on the
   // accepting edge itself, so the live bus fields feed the decode.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cap        = 1'b0;
      access     = 1'b0;
      acc_addr   = addr_reg;
      acc_we     = we_reg;
      acc_wdata  = wdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.req) begin
               cap       = 1'b1;
               acc_addr  = bus.addr;
               acc_we    = bus.we;
               acc_wdata = bus.wdata;
               if (WAIT_STATES == 0) begin
                  state_next = ST_RESP;
                  access     = 1'b1;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = WS_M1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = ST_RESP;
               access     = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign is_ram  = ({16'h0000, acc_addr} < RAM_BYTES);
   assign is_rom  = (acc_addr >= ROM_BASE);
   assign is_mbox = (acc_addr == MBOX_ADDR);

   // State, wait counter and captured request fields.
   always_ff @(posedge ph1) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
      if (cap) begin
         addr_reg  <= bus.addr;
         we_reg    <= bus.we;
         wdata_reg <= bus.wdata;
      end
   end

   // Completion: registered read data, ready pulse and sticky status flags.
   always_ff @(posedge ph1) begin
      if (reset) begin
         ready_reg <= 1'b0;
         rdata_reg <= 8'h00;
         done_reg  <= 1'b0;
         code_reg  <= 8'h00;
         err_reg   <= 1'b0;
      end else begin
         ready_reg <= access;
         if (access) begin
            if (acc_we) begin
               if (is_ram) begin
                  // RAM write handled in the RAM array process
               end else if (is_rom) begin
                  err_reg <= 1'b1;
               end else if (is_mbox) begin
                  code_reg <= acc_wdata;
                  done_reg <= 1'b1;
               end
            end else begin
               if (is_ram)
                  rdata_reg <= ram_mem[RAM_AW'(acc_addr)];
               else if (is_rom)
                  rdata_reg <= rom_mem[ROM_AW'(acc_addr - ROM_BASE)];
               else if (is_mbox)
                  rdata_reg <= code_reg;
               else
                  rdata_reg <= 8'hFF;
            end
         end
      end
   end

   // RAM array write; an access abandoned by reset never commits.
   always_ff @(posedge ph1) begin
      if (!reset && access && acc_we && is_ram)
         ram_mem[RAM_AW'(acc_addr)] <= acc_wdata;
   end

   // ROM array side-load; a same-edge bus read sees the old byte.
   always_ff @(posedge ph1) begin
      if (load_en)
         rom_mem[ROM_AW'(load_addr)] <= load_data;
   end

   assign bus.rdata     = rdata_reg;
   assign bus.ready     = ready_reg;
   assign test_done     = done_reg;
   assign test_code     = code_reg;
   assign err_rom_write = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with no wait states and one with
// three, driven by blocking tasks; a scoreboard queue per instance holds
// the expected completion cycle, read data and flag state.
module tb_mem_responder;

   localparam int WS0 = 0;
   localparam int WS1 = 3;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  data;
      int          cyc;
      logic        mb;
      logic [7:0]  mbv;
      logic        er;
   } exp_t;

   logic        ph1 = 1'b0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_err = 0;

   logic [1:0]  rst_d = 2'b11;
   logic [1:0]  req_d = 2'b00;
   logic [1:0]  we_d = 2'b00;
   logic [15:0] addr_d [2];
   logic [7:0]  wdata_d [2];
   logic [1:0]  load_en_d = 2'b00;
   logic [11:0] load_addr_d [2];
   logic [7:0]  load_data_d [2];

   logic [1:0]  ready_w;
   logic [7:0]  rdata_w [2];
   logic [1:0]  done_w;
   logic [7:0]  code_w [2];
   logic [1:0]  err_w;

   exp_t        sb [2][$];
   logic [7:0]  last_exp [2];
   logic [1:0]  prev_rdy = 2'b00;
   exp_t        mon_e;

   mem_responder_if bus0 ();
   mem_responder_if bus1 ();

   assign bus0.req   = req_d[0];
   assign bus0.addr  = addr_d[0];
   assign bus0.we    = we_d[0];
   assign bus0.wdata = wdata_d[0];
   assign bus1.req   = req_d[1];
   assign bus1.addr  = addr_d[1];
   assign bus1.we    = we_d[1];
   assign bus1.wdata = wdata_d[1];
   assign ready_w    = {bus1.ready, bus0.ready};
   assign rdata_w[0] = bus0.rdata;
   assign rdata_w[1] = bus1.rdata;

   mem_responder #(.WAIT_STATES(WS0)) u_dut0 (
      .ph1(ph1), .reset(rst_d[0]), .bus(bus0),
      .load_en(load_en_d[0]), .load_addr(load_addr_d[0]), .load_data(load_data_d[0]),
      .test_done(done_w[0]), .test_code(code_w[0]), .err_rom_write(err_w[0])
   );

   mem_responder #(.WAIT_STATES(WS1)) u_dut1 (
      .ph1(ph1), .reset(rst_d[1]), .bus(bus1),
      .load_en(load_en_d[1]), .load_addr(load_addr_d[1]), .load_data(load_data_d[1]),
      .test_done(done_w[1]), .test_code(code_w[1]), .err_rom_write(err_w[1])
   );

   always #5 ph1 = ~ph1;

   always @(posedge ph1) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ws_of(input int i);
      return (i == 0) ? WS0 : WS1;
   endfunction

   // Completion monitor: every ready must match the oldest expectation.
   always @(negedge ph1) begin
      for (int i = 0; i < 2; i++) begin
         if (ready_w[i]) begin
            if (sb[i].size() == 0) begin
               chk($sformatf("u%0d unexpected_ready", i), 32'(ready_w[i]), 32'd0);
            end else begin
               mon_e = sb[i].pop_front();
               $display("u%0d cyc %0d %s addr %04h rdata %02h", i, cyc,
                        mon_e.we ? "WR" : "RD", mon_e.addr, rdata_w[i]);
               chk($sformatf("u%0d ready_cycle", i), 32'(cyc), 32'(mon_e.cyc));
               chk($sformatf("u%0d rdata", i), 32'(rdata_w[i]), 32'(mon_e.data));
               chk($sformatf("u%0d back_to_back_ready", i), 32'(prev_rdy[i]), 32'd0);
               if (mon_e.mb) begin
                  chk($sformatf("u%0d test_done", i), 32'(done_w[i]), 32'd1);
                  chk($sformatf("u%0d test_code", i), 32'(code_w[i]), 32'(mon_e.mbv));
               end
               if (mon_e.er)
                  chk($sformatf("u%0d err_rom_write", i), 32'(err_w[i]), 32'd1);
            end
         end
         prev_rdy[i] = ready_w[i];
      end
   end

   task automatic push(input int i, input bit w, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] e);
      exp_t x;
      x.addr = a;
      x.we   = w;
      x.cyc  = cyc + ws_of(i);
      x.data = w ? last_exp[i] : e;
      x.mb   = w && (a == 16'h8000);
      x.mbv  = d;
      x.er   = w && (a >= 16'hF000);
      if (!w) last_exp[i] = e;
      sb[i].push_back(x);
   endtask

   task automatic drain(input int i);
      for (int k = 0; k < 40 && sb[i].size() != 0; k++) begin
         @(posedge ph1); #1;
      end
      if (sb[i].size() != 0) begin
         chk($sformatf("u%0d drain_timeout", i), 32'(sb[i].size()), 32'd0);
         sb[i].delete();
      end
   endtask

   task automatic op(input int i, input bit w, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] e, input bit ld = 1'b0, input logic [7:0] ldv = 8'h00);
      req_d[i]   = 1'b1;
      we_d[i]    = w;
      addr_d[i]  = a;
      wdata_d[i] = d;
      if (ld) begin
         load_en_d[i]   = 1'b1;
         load_addr_d[i] = 12'(a - 16'hF000);
         load_data_d[i] = ldv;
      end
      @(posedge ph1); #1;
      req_d[i]     = 1'b0;
      load_en_d[i] = 1'b0;
      push(i, w, a, d, e);
      drain(i);
   endtask

   task automatic sload_all(input logic [11:0] off, input logic [7:0] v);
      load_en_d      = 2'b11;
      load_addr_d[0] = off;
      load_addr_d[1] = off;
      load_data_d[0] = v;
      load_data_d[1] = v;
      @(posedge ph1); #1;
      load_en_d = 2'b00;
   endtask

   // Keeps req high; the responder should accept once per 2+WS cycles.
   task automatic stream(input int i, input logic [15:0] a0, input logic [7:0] e0,
                         input logic [15:0] a1, input logic [7:0] e1, input int n);
      int p;
      p = 2 + ws_of(i);
      req_d[i] = 1'b1;
      we_d[i]  = 1'b0;
      for (int k = 0; k < n; k++) begin
         addr_d[i] = (k % 2 == 1) ? a1 : a0;
         @(posedge ph1); #1;
         push(i, 1'b0, addr_d[i], 8'h00, (k % 2 == 1) ? e1 : e0);
         if (k != n - 1)
            repeat (p - 1) begin @(posedge ph1); #1; end
      end
      req_d[i] = 1'b0;
      drain(i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         addr_d[i] = 16'h0000; wdata_d[i] = 8'h00;
         load_addr_d[i] = 12'h000; load_data_d[i] = 8'h00;
         last_exp[i] = 8'h00;
      end
      @(posedge ph1); #1;
      // ROM side-load while reset is held
      sload_all(12'hFFC, 8'h00);
      sload_all(12'hFFD, 8'hF0);
      sload_all(12'h010, 8'h55);
      sload_all(12'h020, 8'h11);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d reset ready", i), 32'(ready_w[i]), 32'd0);
         chk($sformatf("u%0d reset rdata", i), 32'(rdata_w[i]), 32'd0);
         chk($sformatf("u%0d reset test_done", i), 32'(done_w[i]), 32'd0);
         chk($sformatf("u%0d reset test_code", i), 32'(code_w[i]), 32'd0);
         chk($sformatf("u%0d reset err", i), 32'(err_w[i]), 32'd0);
      end
      rst_d = 2'b00;
      @(posedge ph1); #1;

      // zero wait states
      op(0, 1'b0, 16'hFFFC, 8'h00, 8'h00);
      op(0, 1'b0, 16'hFFFD, 8'h00, 8'hF0);
      op(0, 1'b1, 16'hF010, 8'hAA, 8'h00);
      op(0, 1'b0, 16'hF010, 8'h00, 8'h55);
      op(0, 1'b1, 16'h8000, 8'h42, 8'h00);
      op(0, 1'b0, 16'h8000, 8'h00, 8'h42);
      op(0, 1'b0, 16'h9000, 8'h00, 8'hFF);
      op(0, 1'b1, 16'h0020, 8'h5A, 8'h00);
      op(0, 1'b0, 16'h0020, 8'h00, 8'h5A);
      op(0, 1'b0, 16'hF020, 8'h00, 8'h11, 1'b1, 8'h22);
      op(0, 1'b0, 16'hF020, 8'h00, 8'h22);

      // three wait states
      op(1, 1'b1, 16'h0040, 8'h42, 8'h00);
      op(1, 1'b0, 16'h0040, 8'h00, 8'h42);
      op(1, 1'b1, 16'h0010, 8'h11, 8'h00);
      op(1, 1'b1, 16'hF010, 8'hAA, 8'h00);
      op(1, 1'b1, 16'h8000, 8'h99, 8'h00);

      // reset in the second WAIT cycle abandons the write
      req_d[1] = 1'b1; we_d[1] = 1'b1; addr_d[1] = 16'h0010; wdata_d[1] = 8'h77;
      @(posedge ph1); #1;
      req_d[1] = 1'b0;
      @(posedge ph1); #1;
      rst_d[1] = 1'b1;
      @(posedge ph1); #1;
      rst_d[1] = 1'b0;
      last_exp[1] = 8'h00;
      chk("u1 midreset ready", 32'(ready_w[1]), 32'd0);
      chk("u1 midreset rdata", 32'(rdata_w[1]), 32'd0);
      chk("u1 midreset test_done", 32'(done_w[1]), 32'd0);
      chk("u1 midreset test_code", 32'(code_w[1]), 32'd0);
      chk("u1 midreset err", 32'(err_w[1]), 32'd0);
      repeat (6) begin @(posedge ph1); #1; end
      op(1, 1'b0, 16'h0010, 8'h00, 8'h11);
      op(1, 1'b0, 16'h8000, 8'h00, 8'h00);

      // continuous requests
      stream(0, 16'hFFFC, 8'h00, 16'hFFFD, 8'hF0, 6);
      stream(1, 16'h0040, 8'h42, 16'h0010, 8'h11, 6);

      repeat (4) begin @(posedge ph1); #1; end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
